hazard_sb: RTL
==============

# hazard_sb

Parametrised successor to the pipeline hazard unit: per-read-port forwarding-select generation, load-use interlock, and a register scoreboard for long-latency (variable-latency) writers that complete outside the ALU pipeline. Sits beside the ID stage of the 5-stage core. Its forwarding selects drive the per-operand 8:1 operand muxes in front of the ID/EX register; its stall drives the ID/EX stall and the IF/ID hold.

## Interface
Parameters:
- NRP, 2, number of register read ports checked
- MAXOUT, 4, maximum outstanding long-latency ops
- CNTW, 16, width of the stall performance counter

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- id_rs_addr  in  NRP*5  source register addresses; port k is bits [5k+4:5k]
- id_rs_used  in  NRP  port k actually reads its register
- id_issue  in  1  ID instruction wants to advance this cycle
- id_rd  in  5  destination of the ID instruction
- id_regwr  in  1  ID instruction writes a register
- id_long  in  1  ID instruction is a long-latency op; result returns on lw_* rather than WB
- ex_rd, mem_rd, wb_rd  in  5 each  stage destination registers
- ex_regwr, mem_regwr, wb_regwr  in  1 each  stage register-write enables
- ex_wbsel, mem_wbsel, wb_wbsel  in  2 each  stage writeback source
- lw_done  in  1  a long-latency result is written to the register file this cycle
- lw_rd  in  5  destination of that result
- fwd_sel  out  NRP*3  per-port operand-mux select; port k is bits [3k+2:3k]
- stall  out  1  hold IF/ID and insert a bubble into ID/EX
- busy  out  32  scoreboard pending bits
- outstanding  out  $clog2(MAXOUT+1)  count of pending long-latency ops
- stall_cnt  out  CNTW  number of stalled cycles; saturates
- err  out  1  sticky flag: lw_done for a non-pending register

## Operation
- Match rule: a stage matches port k if the stage's regwr is set, its rd is nonzero, its rd equals the port's address, and id_rs_used[k] is set.
- Forwarding priority per port: EX, then MEM, then WB, then the register file.
  - EX match with wbsel ALU or PC4 gives 2.
  - MEM match with wbsel ALU or PC4 gives 4.
  - WB match with wbsel ALU or PC4 gives 6.
  - WB match with wbsel MEM gives 7.
  - No match gives 0.
- PC4 writers carry the link value in the ALU result and are forwarded as ALU.
- Load-use interlock: if the highest-priority match for any port is an EX or MEM stage with wbsel MEM, stall=1. While stalled, fwd_sel is still driven but is a don't-care.
- Scoreboard conditions:
  - RAW: any used port reads a busy register (address nonzero). stall=1.
  - WAW: id_issue, id_regwr, and busy[id_rd]. stall=1.
  - Capacity: id_issue, id_long, and outstanding==MAXOUT. stall=1.
- stall is the OR of all stall conditions. It is combinational from the inputs and the current state.
- Accepted issue is id_issue & ~stall.
  - With id_long, id_regwr, and id_rd≠0, it sets busy[id_rd] and increments outstanding.
  - A long op with rd=0 or without regwr still counts in outstanding; it is retired by lw_done with lw_rd=0.
- lw_done with lw_rd≠0: clears busy[lw_rd] and decrements outstanding.
- lw_done with lw_rd=0: decrements outstanding if it is nonzero; otherwise sets err.
- lw_done for a non-busy register (lw_rd≠0): no state change; sets err.
- Simultaneous accepted long issue and lw_done:
  - outstanding is unchanged.
  - If the registers are equal, busy stays set (the issue wins). WAW normally prevents this case.
- No same-cycle bypass from lw_*. A reader of lw_rd stalls in the lw_done cycle and proceeds the next cycle.
- stall_cnt increments on every stall=1 cycle and saturates at all ones.
- busy[0] is always 0.

## Timing
- fwd_sel and stall: zero-cycle combinational path.
- busy, outstanding, err, stall_cnt: update on the rising clk edge and are visible the next cycle.
- Load-use costs 2 bubbles (load in EX, then in MEM); the consumer takes sel 7 on the third cycle.
- Reset: busy=0, outstanding=0, stall_cnt=0, err=0. fwd_sel and stall follow the inputs with empty state.
- Reset mid-operation discards all pending entries immediately. lw_done after reset for a formerly pending register sets err.

## Structure
- Shared core package, which also serves the writeback mux and the decoder:
  - WB_ALU=0, WB_MEM=1, WB_PC4=2.
  - Forward-select constants FWD_RF=0, FWD_EX=2, FWD_MEM=4, FWD_WB_ALU=6, FWD_WB_MEM=7.
- Sub-module fwd_port: combinational per-port match and priority logic, instantiated NRP times via generate.
- Scoreboard register, counters and stall OR live in hazard_sb.

## Test plan
- EX ALU writes x5 and port0 reads x5; MEM also writes x5 -> fwd_sel[2:0]=2, stall=0.
- Load to x7 in EX, port1 reads x7 -> stall=1 for 2 cycles, then fwd_sel[5:3]=7 with the load in WB; stall_cnt=2.
- Long op to x9 accepted; next instruction reads x9 -> stall until the lw_done(x9) cycle inclusive, released the cycle after; busy[9] 1→0.
- MAXOUT=4 long ops to x1..x4 accepted; 5th long issue -> stall=1. Same-cycle lw_done(x1) -> still stalled that cycle, accepted next cycle with outstanding=4.
- lw_done(x12) with x12 not busy -> err=1 and sticky; outstanding unchanged. Reset -> err=0.
- Reads of x0 with matching EX/MEM/WB rd=0 writers, and busy traffic for rd=0 -> fwd_sel=0, no stall.

Source files
------------

// File: rtl/hazard_sb_pkg.sv
// Shared core constants: writeback sources and operand forward selects.
// Also used by the writeback mux and the decoder.
package hazard_sb_pkg;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [2:0] FWD_RF     = 3'd0;
    localparam logic [2:0] FWD_EX     = 3'd2;
    localparam logic [2:0] FWD_MEM    = 3'd4;
    localparam logic [2:0] FWD_WB_ALU = 3'd6;
    localparam logic [2:0] FWD_WB_MEM = 3'd7;

    function automatic logic hit(
        input logic       regwr,
        input logic [4:0] rd,
        input logic [4:0] rs,
        input logic       used
    );
        return regwr & used & (rd != 5'd0) & (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_sb_fwd_port.sv
// Per-read-port forward select and load-use detection.
// Youngest matching stage wins; a load still in EX or MEM cannot forward.
module fwd_port
    import hazard_sb_pkg::*;
(
    input  logic [4:0] rs_addr,
    input  logic       rs_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_regwr,
    input  logic [1:0] ex_wbsel,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwr,
    input  logic [1:0] mem_wbsel,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwr,
    input  logic [1:0] wb_wbsel,
    output logic [2:0] sel,
    output logic       load_use
);

    always_comb begin
        sel      = FWD_RF;
        load_use = 1'b0;
        if (hit(ex_regwr, ex_rd, rs_addr, rs_used)) begin
            sel      = FWD_EX;
            load_use = (ex_wbsel == WB_MEM);
        end else if (hit(mem_regwr, mem_rd, rs_addr, rs_used)) begin
            sel      = FWD_MEM;
            load_use = (mem_wbsel == WB_MEM);
        end else if (hit(wb_regwr, wb_rd, rs_addr, rs_used)) begin
            case (wb_wbsel)
                WB_ALU, WB_PC4: sel = FWD_WB_ALU;
                WB_MEM:         sel = FWD_WB_MEM;
                default:        sel = FWD_RF;
            endcase
        end
    end

endmodule

// File: rtl/hazard_sb.sv
// Hazard unit: operand forwarding, load-use interlock and a
// scoreboard for variable-latency writers retiring on lw_*.
module hazard_sb
    import hazard_sb_pkg::*;
#(
    parameter int NRP    = 2,
    parameter int MAXOUT = 4,
    parameter int CNTW   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NRP*5-1:0]             id_rs_addr,
    input  logic [NRP-1:0]               id_rs_used,
    input  logic                         id_issue,
    input  logic [4:0]                   id_rd,
    input  logic                         id_regwr,
    input  logic                         id_long,
    input  logic [4:0]                   ex_rd,
    input  logic [4:0]                   mem_rd,
    input  logic [4:0]                   wb_rd,
    input  logic                         ex_regwr,
    input  logic                         mem_regwr,
    input  logic                         wb_regwr,
    input  logic [1:0]                   ex_wbsel,
    input  logic [1:0]                   mem_wbsel,
    input  logic [1:0]                   wb_wbsel,
    input  logic                         lw_done,
    input  logic [4:0]                   lw_rd,
    output logic [NRP*3-1:0]             fwd_sel,
    output logic                         stall,
    output logic [31:0]                  busy,
    output logic [$clog2(MAXOUT+1)-1:0]  outstanding,
    output logic [CNTW-1:0]              stall_cnt,
    output logic                         err
);

    localparam int OW = $clog2(MAXOUT + 1);
    localparam logic [OW-1:0] MAXV = OW'(MAXOUT);

    logic [NRP-1:0] load_use;
    logic [NRP-1:0] raw;

    for (genvar k = 0; k < NRP; k++) begin : g_port
        fwd_port u_fwd (
            .rs_addr   (id_rs_addr[5*k +: 5]),
            .rs_used   (id_rs_used[k]),
            .ex_rd     (ex_rd),
            .ex_regwr  (ex_regwr),
            .ex_wbsel  (ex_wbsel),
            .mem_rd    (mem_rd),
            .mem_regwr (mem_regwr),
            .mem_wbsel (mem_wbsel),
            .wb_rd     (wb_rd),
            .wb_regwr  (wb_regwr),
            .wb_wbsel  (wb_wbsel),
            .sel       (fwd_sel[3*k +: 3]),
            .load_use  (load_use[k])
        );
        assign raw[k] = id_rs_used[k]
                      & (id_rs_addr[5*k +: 5] != 5'd0)
                      & busy[id_rs_addr[5*k +: 5]];
    end

    logic waw;
    logic cap;
    logic accept;
    logic issue_long;
    logic set_busy;

    assign waw        = id_issue & id_regwr & busy[id_rd];
    assign cap        = id_issue & id_long & (outstanding == MAXV);
    assign stall      = (|load_use) | (|raw) | waw | cap;
    assign accept     = id_issue & ~stall;
    assign issue_long = accept & id_long;
    assign set_busy   = issue_long & id_regwr & (id_rd != 5'd0);

    logic [31:0]   busy_d;
    logic [OW-1:0] out_d;
    logic          err_d;
    logic          lw_ret;

    always_comb begin
        busy_d = busy;
        out_d  = outstanding;
        err_d  = err;
        lw_ret = 1'b0;
        if (lw_done) begin
            if (lw_rd != 5'd0) begin
                if (busy[lw_rd]) begin
                    busy_d[lw_rd] = 1'b0;
                    lw_ret        = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end else if (outstanding != '0) begin
                lw_ret = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        // Issue applied after retire so a same-register collision stays busy.
        if (set_busy) begin
            busy_d[id_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (issue_long & ~lw_ret) begin
            out_d = outstanding + OW'(1);
        end else if (~issue_long & lw_ret) begin
            out_d = outstanding - OW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= '0;
            outstanding <= '0;
            err         <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            busy        <= busy_d;
            outstanding <= out_d;
            err         <= err_d;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNTW'(1);
            end
        end
    end

endmodule
